lfsr_gen: RTL and testbench

- Parametrised XNOR Fibonacci LFSR pseudo-random word source. Generalised in width, tap polynomial, seed and bits-per-advance.
- Adds warm-up sequencing, runtime reseed, stuck-state recovery and a valid/ready word output.
- Feeds noise, dither and test-pattern consumers in the core. Replaces fixed free-running 64-bit generators.

---
 rtl/lfsr_gen_if.sv | 12 +
 rtl/lfsr_gen.sv | 94 +++++++++
 tb/tb_lfsr_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_gen_if.sv
// Word output channel of lfsr_gen: a valid/ready handshake carrying one
// pseudo-random word. The generator drives it through the master modport.
interface lfsr_gen_if #(
  parameter int OUT_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/lfsr_gen.sv
// XNOR Fibonacci LFSR word source with warm-up sequencing, runtime reseed,
// stuck-state recovery and a valid/ready word output.
module lfsr_gen #(
  parameter int           N      = 64,
  parameter logic [63:0]  TAPS   = 64'hB440_0000_0000_0000,
  parameter logic [N-1:0] SEED   = '1,
  parameter int           STEPS  = 1,
  parameter int           OUT_W  = 16,
  parameter int           WARMUP = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_load,
  input  logic [N-1:0]  seed_data,
  input  logic          free_run,
  lfsr_gen_if.master    bus,
  output logic          stuck,
  output logic [31:0]   word_count
);

  typedef enum logic {
    ST_WARM,
    ST_RUN
  } fsm_t;

  localparam logic [15:0] WARM_INIT = 16'(WARMUP);
  localparam bit          NO_WARM   = (WARMUP == 0);

  fsm_t         fsm;
  logic [N-1:0] state;
  logic [N-1:0] adv_state;
  logic [15:0]  warm_cnt;
  logic         valid;
  logic         accept;
  logic         advance;
  logic         is_stuck;

  function automatic logic [N-1:0] step1(input logic [N-1:0] s);
    return {s[N-2:0], ~^(s & TAPS[N-1:0])};
  endfunction

  // NOTE: adv_state gets its default before the loop, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    adv_state = state;
    for (int k = 0; k < STEPS; k++) begin
      adv_state = step1(adv_state);
    end
  end

  // Warm-up advances unconditionally; in RUN only an accept or free_run does.
  assign accept   = valid & bus.out_ready;
  assign advance  = (fsm == ST_WARM) | accept | free_run;
  assign is_stuck = advance & (adv_state == state);

  assign bus.out_valid = valid;
  assign bus.out_data  = state[OUT_W-1:0];

  // NOTE: all state here is updated with non-blocking assignments so every
  // right-hand side reads the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEED;
      fsm        <= NO_WARM ? ST_RUN : ST_WARM;
      warm_cnt   <= WARM_INIT;
      valid      <= NO_WARM;
      stuck      <= 1'b0;
      word_count <= '0;
    end else begin
      stuck <= 1'b0;
      if (accept) begin
        word_count <= word_count + 32'd1;
      end
      if (seed_load || is_stuck) begin
        // Reseed and stuck recovery share the same re-entry into warm-up.
        state    <= seed_load ? seed_data : SEED;
        fsm      <= NO_WARM ? ST_RUN : ST_WARM;
        warm_cnt <= WARM_INIT;
        valid    <= NO_WARM;
        stuck    <= ~seed_load;
      end else if (advance) begin
        state <= adv_state;
        if (fsm == ST_WARM) begin
          warm_cnt <= warm_cnt - 16'd1;
          if (warm_cnt == 16'd1) begin
            fsm   <= ST_RUN;
            valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: four configurations run side by side against a
// bit-counting reference model, plus hand-computed pin checks.
module tb_lfsr_gen;

  localparam logic [63:0] DTAPS = 64'hB440_0000_0000_0000;

  // Per-instance configuration: 0 defaults, 1 warm-up/multi-step,
  // 2 small stuck-prone LFSR, 3 reseed with warm-up.
  localparam int          C_N     [4] = '{64, 64, 8, 64};
  localparam logic [63:0] C_TAPS  [4] = '{DTAPS, DTAPS, 64'hC0, DTAPS};
  localparam logic [63:0] C_SEED  [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                          64'h01, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam int          C_STEPS [4] = '{1, 4, 1, 2};
  localparam int          C_WARM  [4] = '{0, 4, 0, 3};
  localparam int          C_OW    [4] = '{16, 16, 8, 16};

  logic clk = 1'b0;
  logic rst;
  logic [3:0]        sl;
  logic [3:0][63:0]  sd;
  logic [3:0]        fr;
  logic [3:0]        rdy;
  logic [3:0]        stk;
  logic [3:0][31:0]  cnt;
  logic [3:0][63:0]  act_state;
  logic [3:0][63:0]  act_data;
  logic [3:0]        act_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_gen_if #(.OUT_W(16)) if0 ();
  lfsr_gen_if #(.OUT_W(16)) if1 ();
  lfsr_gen_if #(.OUT_W(8))  if2 ();
  lfsr_gen_if #(.OUT_W(16)) if3 ();

  lfsr_gen u0 (
    .clk(clk), .reset(rst), .seed_load(sl[0]), .seed_data(sd[0]), .free_run(fr[0]),
    .bus(if0.master), .stuck(stk[0]), .word_count(cnt[0])
  );
  lfsr_gen #(.STEPS(4), .WARMUP(4)) u1 (
    .clk(clk), .reset(rst), .seed_load(sl[1]), .seed_data(sd[1]), .free_run(fr[1]),
    .bus(if1.master), .stuck(stk[1]), .word_count(cnt[1])
  );
  lfsr_gen #(.N(8), .TAPS(64'hC0), .SEED(8'h01), .OUT_W(8)) u2 (
    .clk(clk), .reset(rst), .seed_load(sl[2]), .seed_data(sd[2][7:0]), .free_run(fr[2]),
    .bus(if2.master), .stuck(stk[2]), .word_count(cnt[2])
  );
  lfsr_gen #(.STEPS(2), .WARMUP(3)) u3 (
    .clk(clk), .reset(rst), .seed_load(sl[3]), .seed_data(sd[3]), .free_run(fr[3]),
    .bus(if3.master), .stuck(stk[3]), .word_count(cnt[3])
  );

  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];
  assign if2.out_ready = rdy[2];
  assign if3.out_ready = rdy[3];

  assign act_valid = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  assign act_data[0]  = {48'd0, if0.out_data};
  assign act_data[1]  = {48'd0, if1.out_data};
  assign act_data[2]  = {56'd0, if2.out_data};
  assign act_data[3]  = {48'd0, if3.out_data};
  assign act_state[0] = u0.state;
  assign act_state[1] = u1.state;
  assign act_state[2] = {56'd0, u2.state};
  assign act_state[3] = u3.state;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] wmask(input int n);
    return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  // Feedback is 1 exactly when an even number of tapped bits are set.
  function automatic logic [63:0] m_advance(input int idx, input logic [63:0] s);
    logic [63:0] r;
    int ones;
    r = s;
    for (int k = 0; k < C_STEPS[idx]; k++) begin
      ones = 0;
      for (int b = 0; b < C_N[idx]; b++) begin
        if (C_TAPS[idx][b] && r[b]) ones++;
      end
      r = ((r << 1) | 64'((ones % 2) == 0)) & wmask(C_N[idx]);
    end
    return r;
  endfunction

  logic [63:0] m_state [4];
  int          m_warm  [4];
  logic [31:0] m_count [4];
  logic        m_stuck [4];
  logic        m_ok = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin : mdl
      automatic logic        acc = (m_warm[i] == 0) && rdy[i];
      automatic logic        adv = (m_warm[i] != 0) || acc || fr[i];
      automatic logic [63:0] nxt = m_advance(i, m_state[i]);
      if (rst) begin
        m_state[i] <= C_SEED[i] & wmask(C_N[i]);
        m_warm[i]  <= C_WARM[i];
        m_count[i] <= '0;
        m_stuck[i] <= 1'b0;
      end else begin
        m_stuck[i] <= 1'b0;
        if (acc) m_count[i] <= m_count[i] + 32'd1;
        if (sl[i]) begin
          m_state[i] <= sd[i] & wmask(C_N[i]);
          m_warm[i]  <= C_WARM[i];
        end else if (adv && nxt == m_state[i]) begin
          m_state[i] <= C_SEED[i] & wmask(C_N[i]);
          m_warm[i]  <= C_WARM[i];
          m_stuck[i] <= 1'b1;
        end else if (adv) begin
          m_state[i] <= nxt;
          if (m_warm[i] > 0) m_warm[i] <= m_warm[i] - 1;
        end
      end
    end
    m_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("u%0d valid", i), 64'(act_valid[i]), 64'(m_warm[i] == 0));
        check($sformatf("u%0d data", i),  act_data[i], m_state[i] & wmask(C_OW[i]));
        check($sformatf("u%0d state", i), act_state[i], m_state[i]);
        check($sformatf("u%0d stuck", i), 64'(stk[i]), 64'(m_stuck[i]));
        check($sformatf("u%0d count", i), 64'(cnt[i]), 64'(m_count[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] bp_exp [4];
  logic [3:0]  bp_rdy;

  initial begin
    rst = 1'b1; sl = '0; sd = '0; fr = '0; rdy = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("rst u0 data",  act_data[0], 64'hFFFF);
    check("rst u0 valid", 64'(act_valid[0]), 64'd1);
    check("rst u0 count", 64'(cnt[0]), 64'd0);
    check("rst u1 valid", 64'(act_valid[1]), 64'd0);
    check("rst u2 data",  act_data[2], 64'h01);

    // Defaults with every word accepted; u1 warms up alongside.
    rdy[0] = 1'b1;
    tick();
    check("acc1 u0 data",  act_data[0], 64'hFFFE);
    check("acc1 u0 count", 64'(cnt[0]), 64'd1);
    tick();
    check("acc2 u0 data", act_data[0], 64'hFFFC);
    tick();
    check("warm3 u1 valid", 64'(act_valid[1]), 64'd0);
    tick();
    check("warm4 u1 valid", 64'(act_valid[1]), 64'd1);
    check("warm4 u1 state", act_state[1], 64'hFFFF_FFFF_FFFF_0000);
    check("warm4 u1 data",  act_data[1], 64'h0000);
    repeat (6) tick();
    check("acc10 u0 state", act_state[0], 64'hFFFF_FFFF_FFFF_FC00);
    check("acc10 u0 count", 64'(cnt[0]), 64'd10);
    rdy[0] = 1'b0;

    repeat (3) tick();
    check("hold u1 state", act_state[1], 64'hFFFF_FFFF_FFFF_0000);
    check("hold u0 state", act_state[0], 64'hFFFF_FFFF_FFFF_FC00);

    // Backpressure: ready 1,0,0,1 gives exactly two advances.
    bp_rdy = 4'b1001;
    bp_exp = '{16'hF800, 16'hF800, 16'hF800, 16'hF000};
    for (int k = 0; k < 4; k++) begin
      rdy[0] = bp_rdy[3-k];
      tick();
      check($sformatf("bp%0d u0 data", k), act_data[0], 64'(bp_exp[k]));
    end
    rdy[0] = 1'b0;
    check("bp u0 count", 64'(cnt[0]), 64'd12);

    // Free run without acceptance: five advances, nothing counted.
    fr[0] = 1'b1;
    repeat (5) tick();
    fr[0] = 1'b0;
    check("fr u0 state", act_state[0], 64'hFFFF_FFFF_FFFE_0000);
    check("fr u0 count", 64'(cnt[0]), 64'd12);

    // Load a stuck value into the 8-bit LFSR, then advance it.
    sd[2] = 64'hFF; sl[2] = 1'b1;
    tick();
    sl[2] = 1'b0;
    check("load u2 data",  act_data[2], 64'hFF);
    check("load u2 valid", 64'(act_valid[2]), 64'd1);
    fr[2] = 1'b1;
    tick();
    check("stk u2 stuck", 64'(stk[2]), 64'd1);
    check("stk u2 data",  act_data[2], 64'h01);
    check("stk u2 count", 64'(cnt[2]), 64'd0);
    tick();
    check("post u2 stuck", 64'(stk[2]), 64'd0);
    check("post u2 data",  act_data[2], 64'h03);
    fr[2] = 1'b0;

    // u3: two accepts, then reseed to zero with a concurrent handshake.
    rdy[3] = 1'b1;
    repeat (2) tick();
    check("acc u3 data",  act_data[3], 64'hFC00);
    check("acc u3 count", 64'(cnt[3]), 64'd2);
    sd[3] = 64'd0; sl[3] = 1'b1;
    tick();
    sl[3] = 1'b0;
    check("rs0 u3 valid", 64'(act_valid[3]), 64'd0);
    check("rs0 u3 count", 64'(cnt[3]), 64'd3);
    check("rs0 u3 state", act_state[3], 64'd0);
    tick();
    check("rs1 u3 valid", 64'(act_valid[3]), 64'd0);
    tick();
    check("rs2 u3 valid", 64'(act_valid[3]), 64'd0);
    tick();
    check("rs3 u3 valid", 64'(act_valid[3]), 64'd1);
    check("rs3 u3 state", act_state[3], 64'h3F);
    check("rs3 u3 count", 64'(cnt[3]), 64'd3);
    rdy[3] = 1'b0;

    // Reset together with seed_load: reset wins.
    sd[2] = 64'hFF; sl[2] = 1'b1; sd[0] = 64'd0; sl[0] = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; sl = '0;
    check("rsl u2 data",  act_data[2], 64'h01);
    check("rsl u0 state", act_state[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("rsl u0 count", 64'(cnt[0]), 64'd0);
    check("rsl u3 count", 64'(cnt[3]), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
